// File: rtl/level_pkg.sv
// -----------------------------------------------------------------------------
// level_pkg
// Shared definitions for the tank level alarm controller:
//   - state_t   : alarm FSM state codes (also exported on the debug state port)
//   - LEVEL_W   : width of level/threshold buses
//   - MAX_LEVEL : largest legal level sample in percent
//   - CNT_W     : width of the persistence counter (PERSIST up to 15)
//   - is_alarm(): true for the two latched alarm states
// -----------------------------------------------------------------------------
package level_pkg;

    localparam int LEVEL_W   = 8;
    localparam int MAX_LEVEL = 100;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_NORMAL     = 3'd0,
        ST_HIGH_PEND  = 3'd1,
        ST_HIGH_ALARM = 3'd2,
        ST_LOW_PEND   = 3'd3,
        ST_LOW_ALARM  = 3'd4
    } state_t;

    function automatic logic is_alarm(input state_t s);
        return (s == ST_HIGH_ALARM) || (s == ST_LOW_ALARM);
    endfunction

endpackage

// File: rtl/blink_gen.sv
// -----------------------------------------------------------------------------
// blink_gen
// Free-running divider that toggles its output every DIV clock cycles.
// The counter runs 0..DIV-1 and wraps; the toggle happens on the wrap.
// Ports:
//   clk_100MHz : system clock
//   reset      : asynchronous, active-high reset (counter and output to 0)
//   blink      : square wave, half period = DIV cycles
// -----------------------------------------------------------------------------
module blink_gen #(
    parameter int DIV = 25_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    output logic blink
);

    localparam int             CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_blink;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign blink = r_blink;

endmodule

// File: rtl/level_alarm_controller.sv
// -----------------------------------------------------------------------------
// level_alarm_controller
// Watches level samples against programmed high/low thresholds, raises
// persistence-filtered alarms that clear with hysteresis, runs the fill pump
// (on at low alarm, off once the level reaches the high threshold) and drives
// an alarm LED that blinks until acknowledged.
// Ports:
//   clk_100MHz     : system clock
//   reset          : asynchronous, active-high reset
//   level          : level sample in percent (legal 0..100)
//   level_valid    : one-cycle strobe qualifying level
//   high_threshold : live high threshold, percent
//   low_threshold  : live low threshold, percent
//   ack_button     : one-cycle operator acknowledge
//   alarm_high     : in high alarm
//   alarm_low      : in low alarm
//   pump_on        : fill pump enable
//   alarm_led      : blinking (unacked) / steady (acked) while an alarm is up
//   sensor_fault   : last valid sample was above 100
//   state          : FSM state code for debug/display
// -----------------------------------------------------------------------------
module level_alarm_controller
    import level_pkg::*;
#(
    parameter int PERSIST   = 4,
    parameter int HYST      = 2,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    input  logic               level_valid,
    input  logic [LEVEL_W-1:0] high_threshold,
    input  logic [LEVEL_W-1:0] low_threshold,
    input  logic               ack_button,
    output logic               alarm_high,
    output logic               alarm_low,
    output logic               pump_on,
    output logic               alarm_led,
    output logic               sensor_fault,
    output logic [2:0]         state
);

    localparam logic [8:0]         HYST9       = 9'(HYST);
    localparam logic [CNT_W-1:0]   PERSIST_CNT = CNT_W'(PERSIST);
    localparam logic [LEVEL_W-1:0] MAX_LVL     = LEVEL_W'(MAX_LEVEL);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic             r_alarm_high, r_alarm_low;
    logic             r_pump, w_pump_next;
    logic             r_fault, w_fault_next;
    logic             r_ack, w_ack_next;
    logic             w_blink;

    // Comparisons are done one bit wider so level+HYST and low+HYST never wrap.
    logic [8:0] w_level9, w_high9, w_low9;
    logic       w_legal, w_hi, w_lo, w_hi_clr, w_lo_clr;
    logic       w_alarm_now, w_alarm_next, w_enter_high, w_enter_low;

    assign w_level9  = {1'b0, level};
    assign w_high9   = {1'b0, high_threshold};
    assign w_low9    = {1'b0, low_threshold};
    assign w_legal   = level_valid && (level <= MAX_LVL);
    assign w_hi      = w_level9 > w_high9;
    assign w_lo      = w_level9 < w_low9;
    assign w_hi_clr  = (w_level9 + HYST9) <= w_high9;
    assign w_lo_clr  = w_level9 >= (w_low9 + HYST9);
    assign w_cnt_inc = r_cnt + 1'b1;

    // Next-state logic. Only legal valid samples can move the FSM; an
    // out-of-range sample leaves both state and persistence count untouched.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_legal) begin
            unique case (r_state)
                ST_NORMAL: begin
                    // hi is tested first so inverted thresholds favour high.
                    if (w_hi) begin
                        if (PERSIST_CNT == CNT_W'(1)) begin
                            w_state_next = ST_HIGH_ALARM;
                            w_cnt_next   = '0;
                        end else begin
                            w_state_next = ST_HIGH_PEND;
                            w_cnt_next   = CNT_W'(1);
                        end
                    end else if (w_lo) begin
                        if (PERSIST_CNT == CNT_W'(1)) begin
                            w_state_next = ST_LOW_ALARM;
                            w_cnt_next   = '0;
                        end else begin
                            w_state_next = ST_LOW_PEND;
                            w_cnt_next   = CNT_W'(1);
                        end
                    end
                end
                ST_HIGH_PEND: begin
                    if (!w_hi) begin
                        w_state_next = ST_NORMAL;
                        w_cnt_next   = '0;
                    end else if (w_cnt_inc == PERSIST_CNT) begin
                        w_state_next = ST_HIGH_ALARM;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = w_cnt_inc;
                    end
                end
                ST_LOW_PEND: begin
                    if (!w_lo) begin
                        w_state_next = ST_NORMAL;
                        w_cnt_next   = '0;
                    end else if (w_cnt_inc == PERSIST_CNT) begin
                        w_state_next = ST_LOW_ALARM;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = w_cnt_inc;
                    end
                end
                ST_HIGH_ALARM: begin
                    if (w_hi_clr) begin
                        w_state_next = ST_NORMAL;
                        w_cnt_next   = '0;
                    end
                end
                ST_LOW_ALARM: begin
                    if (w_lo_clr) begin
                        w_state_next = ST_NORMAL;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    w_state_next = ST_NORMAL;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign w_alarm_now  = is_alarm(r_state);
    assign w_alarm_next = is_alarm(w_state_next);
    assign w_enter_high = (w_state_next == ST_HIGH_ALARM) && (r_state != ST_HIGH_ALARM);
    assign w_enter_low  = (w_state_next == ST_LOW_ALARM)  && (r_state != ST_LOW_ALARM);

    // Pump, fault and acknowledge next values.
    always_comb begin
        w_pump_next  = r_pump;
        w_fault_next = r_fault;
        w_ack_next   = r_ack;

        // Entering low alarm wins over the fill-complete clear; with inverted
        // thresholds the two can coincide and starting the fill is the safe side.
        if (w_enter_low) begin
            w_pump_next = 1'b1;
        end else if (w_enter_high || (w_legal && (level >= high_threshold))) begin
            w_pump_next = 1'b0;
        end

        if (level_valid) begin
            w_fault_next = (level > MAX_LVL);
        end

        // Transition is resolved before the button: an ack arriving on the
        // same cycle an alarm starts or ends is dropped.
        if (w_alarm_now != w_alarm_next) begin
            w_ack_next = 1'b0;
        end else if (ack_button && w_alarm_now) begin
            w_ack_next = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state      <= ST_NORMAL;
            r_cnt        <= '0;
            r_alarm_high <= 1'b0;
            r_alarm_low  <= 1'b0;
            r_pump       <= 1'b0;
            r_fault      <= 1'b0;
            r_ack        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_alarm_high <= (w_state_next == ST_HIGH_ALARM);
            r_alarm_low  <= (w_state_next == ST_LOW_ALARM);
            r_pump       <= w_pump_next;
            r_fault      <= w_fault_next;
            r_ack        <= w_ack_next;
        end
    end

    blink_gen #(
        .DIV(BLINK_DIV)
    ) u_blink_gen (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .blink     (w_blink)
    );

    assign alarm_high   = r_alarm_high;
    assign alarm_low    = r_alarm_low;
    assign pump_on      = r_pump;
    assign sensor_fault = r_fault;
    assign state        = r_state;
    assign alarm_led    = (r_alarm_high | r_alarm_low) & (r_ack | w_blink);

endmodule

// File: tb/tb_level_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_level_alarm_controller
// Directed scenarios with literal expectations followed by randomized samples,
// all compared every cycle against a behavioural model of the alarm rules.
// -----------------------------------------------------------------------------
module tb_level_alarm_controller;

    localparam int P  = 4;
    localparam int H  = 2;
    localparam int BD = 4;

    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] level = '0;
    logic       level_valid = 1'b0;
    logic [7:0] high_threshold = 8'd100;
    logic [7:0] low_threshold = 8'd0;
    logic       ack_button = 1'b0;
    logic       alarm_high, alarm_low, pump_on, alarm_led, sensor_fault;
    logic [2:0] state;

    level_alarm_controller #(
        .PERSIST  (P),
        .HYST     (H),
        .BLINK_DIV(BD)
    ) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .level         (level),
        .level_valid   (level_valid),
        .high_threshold(high_threshold),
        .low_threshold (low_threshold),
        .ack_button    (ack_button),
        .alarm_high    (alarm_high),
        .alarm_low     (alarm_low),
        .pump_on       (pump_on),
        .alarm_led     (alarm_led),
        .sensor_fault  (sensor_fault),
        .state         (state)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    // ---------------- behavioural model ----------------
    // Pending phases are tracked as run lengths of qualifying samples; the
    // alarms are plain booleans; blink phase is derived from elapsed cycles.
    int m_run_hi, m_run_lo, m_k;
    bit m_ah, m_al, m_pump, m_fault, m_ack;

    task automatic model_reset();
        m_run_hi = 0; m_run_lo = 0; m_k = 0;
        m_ah = 0; m_al = 0; m_pump = 0; m_fault = 0; m_ack = 0;
    endtask

    task automatic model_step();
        bit prev_alarm, hi, lo, hc, lc, ent_h, ent_l;
        int lv, hth, lth;
        m_k = (m_k + 1) % (2 * BD);
        prev_alarm = m_ah || m_al;
        ent_h = 0; ent_l = 0;
        if (level_valid) begin
            lv = int'(level); hth = int'(high_threshold); lth = int'(low_threshold);
            if (lv > 100) begin
                m_fault = 1;
            end else begin
                m_fault = 0;
                hi = lv > hth;      lo = lv < lth;
                hc = lv + H <= hth; lc = lv >= lth + H;
                if (m_ah) begin
                    if (hc) m_ah = 0;
                end else if (m_al) begin
                    if (lc) m_al = 0;
                end else if (m_run_hi > 0) begin
                    if (hi) m_run_hi++; else m_run_hi = 0;
                end else if (m_run_lo > 0) begin
                    if (lo) m_run_lo++; else m_run_lo = 0;
                end else if (hi) begin
                    m_run_hi = 1;
                end else if (lo) begin
                    m_run_lo = 1;
                end
                if (m_run_hi >= P) begin m_run_hi = 0; m_ah = 1; ent_h = 1; end
                if (m_run_lo >= P) begin m_run_lo = 0; m_al = 1; ent_l = 1; end
                if (ent_l) m_pump = 1;
                else if (ent_h || lv >= hth) m_pump = 0;
            end
        end
        if (prev_alarm != (m_ah || m_al)) m_ack = 0;
        else if (ack_button && prev_alarm) m_ack = 1;
    endtask

    function automatic int m_state_code();
        if (m_ah) return 2;
        if (m_al) return 4;
        if (m_run_hi > 0) return 1;
        if (m_run_lo > 0) return 3;
        return 0;
    endfunction

    function automatic bit m_led();
        return (m_ah || m_al) && (m_ack || ((m_k / BD) % 2 == 1));
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk_100MHz or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_100MHz) begin
        if (cmp_en) begin
            check("alarm_high",   32'(alarm_high),   32'(m_ah));
            check("alarm_low",    32'(alarm_low),    32'(m_al));
            check("pump_on",      32'(pump_on),      32'(m_pump));
            check("sensor_fault", 32'(sensor_fault), 32'(m_fault));
            check("state",        32'(state),        32'(m_state_code()));
            check("alarm_led",    32'(alarm_led),    32'(m_led()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sample(input int lv);
        @(negedge clk_100MHz);
        level = 8'(lv);
        level_valid = 1'b1;
        @(negedge clk_100MHz);
        level_valid = 1'b0;
        $display("[TB] sample %0d hi_th=%0d lo_th=%0d -> state=%0d ah=%0d al=%0d pump=%0d fault=%0d",
                 lv, high_threshold, low_threshold, state, alarm_high, alarm_low, pump_on, sensor_fault);
    endtask

    task automatic pulse_ack();
        @(negedge clk_100MHz);
        ack_button = 1'b1;
        @(negedge clk_100MHz);
        ack_button = 1'b0;
        $display("[TB] ack pulse -> led=%0d", alarm_led);
    endtask

    // Observe the LED on 17 consecutive falling edges.
    task automatic watch_led(output int trans, output int ones);
        logic prev;
        prev  = alarm_led;
        ones  = int'(alarm_led);
        trans = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_100MHz);
            if (alarm_led != prev) trans++;
            prev = alarm_led;
            ones += int'(alarm_led);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int trans, ones, base, lv, regime;

        @(negedge clk_100MHz);
        cmp_en = 1'b1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_pump",  32'(pump_on), 32'd0);
        check("rst_led",   32'(alarm_led), 32'd0);
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;

        // Default thresholds: nothing alarms.
        sample(0); sample(50); sample(100);
        check("dflt_state", 32'(state), 32'd0);
        check("dflt_pump",  32'(pump_on), 32'd0);

        // High alarm after four samples, hysteresis on clear.
        high_threshold = 8'd75; low_threshold = 8'd25;
        sample(80); sample(80); sample(80);
        check("hpend_state", 32'(state), 32'd1);
        check("hpend_alarm", 32'(alarm_high), 32'd0);
        sample(80);
        check("halarm", 32'(alarm_high), 32'd1);
        check("halarm_state", 32'(state), 32'd2);
        sample(74);
        check("hyst_hold", 32'(alarm_high), 32'd1);
        sample(73);
        check("hyst_clear", 32'(alarm_high), 32'd0);
        check("hyst_state", 32'(state), 32'd0);
        sample(80); sample(80); sample(80); sample(70);
        check("hbreak_state", 32'(state), 32'd0);
        check("hbreak_alarm", 32'(alarm_high), 32'd0);

        // Low alarm, pump, blink and acknowledge.
        sample(10); sample(10); sample(10); sample(10);
        check("lalarm", 32'(alarm_low), 32'd1);
        check("lalarm_pump", 32'(pump_on), 32'd1);
        watch_led(trans, ones);
        check("blink_toggles", 32'(trans), 32'd4);
        pulse_ack();
        watch_led(trans, ones);
        check("ack_steady", 32'(ones), 32'd17);
        sample(30);
        check("lclear", 32'(alarm_low), 32'd0);
        check("lclear_pump", 32'(pump_on), 32'd1);
        check("lclear_led", 32'(alarm_led), 32'd0);
        sample(75);
        check("fill_done_pump", 32'(pump_on), 32'd0);
        sample(10); sample(10); sample(10); sample(10);
        check("lalarm2", 32'(alarm_low), 32'd1);
        watch_led(trans, ones);
        check("reblink_toggles", 32'(trans), 32'd4);
        sample(50);

        // Sensor fault leaves the persistence count alone.
        sample(80);
        sample(120);
        check("fault_set", 32'(sensor_fault), 32'd1);
        check("fault_state", 32'(state), 32'd1);
        sample(80); sample(80);
        check("fault_cnt_hold", 32'(alarm_high), 32'd0);
        sample(80);
        check("fault_cnt_alarm", 32'(alarm_high), 32'd1);
        sample(50);
        check("fault_clear", 32'(sensor_fault), 32'd0);
        check("fault_clear_state", 32'(state), 32'd0);

        // Asynchronous reset in the middle of a pending phase.
        sample(80);
        #2;
        reset = 1'b1;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_fault", 32'(sensor_fault), 32'd0);
        check("async_ah", 32'(alarm_high), 32'd0);
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;

        // Randomized regime-based stimulus.
        regime = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_100MHz);
            if (i % 250 == 0) begin
                high_threshold = 8'($urandom_range(40, 100));
                low_threshold  = 8'($urandom_range(0, 60));
            end
            if (i % 12 == 0) regime = int'($urandom_range(0, 2));
            base = (regime == 0) ? int'(high_threshold) + 3 :
                   (regime == 1) ? int'(low_threshold) - 3 : 50;
            lv = base + int'($urandom_range(0, 8)) - 4;
            if (lv < 0) lv = 0;
            if ($urandom_range(0, 24) == 0) lv = int'($urandom_range(101, 140));
            level       = 8'(lv);
            level_valid = ($urandom_range(0, 2) != 0);
            ack_button  = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk_100MHz);
        level_valid = 1'b0;
        ack_button  = 1'b0;
        repeat (4) @(negedge clk_100MHz);
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/level_alarm_controller.md
Name: level_alarm_controller

Overview:
Consumes the programmed high/low thresholds and the live level samples (0–100 %). It raises high/low alarms with persistence filtering and hysteresis, and drives a fill-pump enable. It also drives a blinking alarm LED that an operator can acknowledge. It sits downstream of the threshold programmer and upstream of the display/LED/pump outputs.

Parameters:
PERSIST, 4, consecutive valid samples beyond a threshold needed to enter an alarm (1..15)
HYST, 2, hysteresis in percent points for alarm clearing
BLINK_DIV, 25_000_000, clk cycles per LED toggle (2 Hz blink at 100 MHz)

Ports:
clk_100MHz  input  1  system clock
reset  input  1  asynchronous, active-high reset
level  input  8  measured level in percent; legal range 0..100
level_valid  input  1  one-cycle strobe; level is sampled only when high
high_threshold  input  8  programmed high threshold, percent
low_threshold  input  8  programmed low threshold, percent
ack_button  input  1  single-cycle acknowledge pulse, already debounced upstream
alarm_high  output  1  high-level alarm active
alarm_low  output  1  low-level alarm active
pump_on  output  1  fill-pump enable
alarm_led  output  1  blinking while unacknowledged; steady while acknowledged; off otherwise
sensor_fault  output  1  last valid sample was >100
state  output  3  FSM state code, for debug/display

Behaviour:
- Reset (async): FSM=NORMAL, persist counter=0, all outputs 0, blink counter=0, ack flag=0.
- FSM states: NORMAL, HIGH_PEND, HIGH_ALARM, LOW_PEND, LOW_ALARM. All transitions are evaluated only on cycles where level_valid=1; otherwise the state holds.
- Sample handling: a sample with level>100 sets sensor_fault=1, is ignored for the FSM (no transition, no counter change), and does not affect pump_on. A legal sample clears sensor_fault.
- Conditions (9-bit arithmetic, no wrap):
  - hi = level > high_threshold
  - lo = level < low_threshold
  - hi_clr = level+HYST <= high_threshold
  - lo_clr = level >= low_threshold+HYST
  - If hi and lo are both true (inverted thresholds), hi has priority.
- NORMAL: hi -> HIGH_PEND with cnt=1; lo -> LOW_PEND with cnt=1; else stay.
- HIGH_PEND: hi -> cnt+1; when cnt+1==PERSIST -> HIGH_ALARM. !hi -> NORMAL with cnt=0. LOW_PEND is symmetric with lo. With PERSIST=1, NORMAL goes directly to the alarm state on the first qualifying sample.
- HIGH_ALARM: hi_clr -> NORMAL, else stay. LOW_ALARM: lo_clr -> NORMAL, else stay. Thresholds are the live inputs, so a threshold change mid-alarm takes effect on the next valid sample.
- Outputs:
  - alarm_high = (state==HIGH_ALARM); alarm_low = (state==LOW_ALARM). Both are registered and update the cycle after the deciding sample.
  - state encoding: NORMAL=0, HIGH_PEND=1, HIGH_ALARM=2, LOW_PEND=3, LOW_ALARM=4.
- Pump: pump_on is set on entry to LOW_ALARM. It is cleared on the first legal sample with level >= high_threshold, or on entry to HIGH_ALARM. Clearing the low alarm alone does not clear the pump (fill to high).
- Acknowledge:
  - ack_button while in an alarm state sets the ack flag. ack_button in any other state is ignored.
  - The ack flag clears on any transition into or out of an alarm state.
  - alarm_led = alarm-active & (ack ? 1 : blink), where blink toggles every BLINK_DIV cycles.
  - The blink counter free-runs and wraps to 0 at BLINK_DIV-1.
- ack_button and level_valid in the same cycle: the FSM transition is evaluated first. If the state leaves or enters an alarm, the ack is discarded.

Decomposition:
- Package level_pkg: FSM state enum/localparams (NORMAL=0, HIGH_PEND=1, HIGH_ALARM=2, LOW_PEND=3, LOW_ALARM=4), MAX_LEVEL=100, LEVEL_W=8.
- One sub-module: blink_gen, a parameterised free-running divider producing a toggle (BLINK_DIV). The benches override it with a small value.

Test Plan:
- Reset defaults (high=100, low=0), feed levels 0, 50, 100 -> no alarm; state=0, pump_on=0.
- high=75, PERSIST=4, four valid samples of 80 -> alarm_high=1 the cycle after the 4th sample. Three samples of 80 then one of 70 -> back to NORMAL, no alarm.
- In HIGH_ALARM (high=75, HYST=2), sample 74 -> stays in alarm; sample 73 -> NORMAL, alarm_high=0.
- low=25, four samples of 10 -> alarm_low=1, pump_on=1. Sample 30 -> alarm clears, pump stays 1. Sample 75 with high=75 -> pump_on=0.
- BLINK_DIV=4, in LOW_ALARM -> alarm_led toggles every 4 cycles. Pulse ack_button -> alarm_led steady 1. Alarm clears -> led 0. Re-entering alarm -> blinking resumes.
- Sample 120 -> sensor_fault=1, state and counter unchanged. Then sample 50 -> sensor_fault=0. Assert reset mid-HIGH_PEND -> all outputs 0 immediately (async).
